// File: rtl/bip_core.sv
// bip_core: multi-cycle accumulator CPU with start/halt control and a
// saturating cycle counter for program benchmarking.
module bip_core #(
    parameter int unsigned DBITS = 16,
    parameter int unsigned IBITS = 16,
    parameter int unsigned ADDR  = 11,
    parameter int unsigned CBITS = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [IBITS-1:0] i_instdata,
    input  logic [DBITS-1:0] i_data_dm,
    output logic [ADDR-1:0]  o_addr_pm,
    output logic [ADDR-1:0]  o_addr_dm,
    output logic             o_Rd,
    output logic             o_Wr,
    output logic [DBITS-1:0] o_data_dm,
    output logic [DBITS-1:0] o_acc,
    output logic             o_done,
    output logic [CBITS-1:0] o_cycles
);

    localparam int unsigned OPW = 5;

    localparam logic [OPW-1:0] OP_HLT  = 5'b00000;
    localparam logic [OPW-1:0] OP_STO  = 5'b00001;
    localparam logic [OPW-1:0] OP_LD   = 5'b00010;
    localparam logic [OPW-1:0] OP_LDI  = 5'b00011;
    localparam logic [OPW-1:0] OP_ADD  = 5'b00100;
    localparam logic [OPW-1:0] OP_ADDI = 5'b00101;
    localparam logic [OPW-1:0] OP_SUB  = 5'b00110;
    localparam logic [OPW-1:0] OP_SUBI = 5'b00111;

    localparam logic [CBITS-1:0] CYC_MAX = {CBITS{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_EXEC,
        ST_HALT
    } state_e;

    state_e             state_q, state_d;
    logic [ADDR-1:0]    pc_q, pc_d;
    logic [DBITS-1:0]   acc_q, acc_d;
    logic [CBITS-1:0]   cyc_q, cyc_d;

    logic [OPW-1:0]     opcode;
    logic [ADDR-1:0]    operand;
    logic [DBITS-1:0]   imm;
    logic               rd_c;
    logic               wr_c;
    logic [ADDR-1:0]    addr_dm_c;

    // Instruction field split; immediate is the sign-extended operand.
    assign opcode  = i_instdata[IBITS-1 -: OPW];
    assign operand = i_instdata[ADDR-1:0];
    assign imm     = DBITS'($signed(operand));

    // State, PC, accumulator and cycle counter registers.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
            acc_q   <= '0;
            cyc_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            acc_q   <= acc_d;
            cyc_q   <= cyc_d;
        end
    end

    // Sequencing, decode/execute and data-memory strobes.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        acc_d     = acc_q;
        cyc_d     = cyc_q;
        rd_c      = 1'b0;
        wr_c      = 1'b0;
        addr_dm_c = '0;

        if ((state_q == ST_FETCH || state_q == ST_EXEC) && cyc_q != CYC_MAX) begin
            cyc_d = cyc_q + CBITS'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                addr_dm_c = operand;
                state_d   = ST_FETCH;
                pc_d      = pc_q + ADDR'(1);
                case (opcode)
                    OP_HLT: begin
                        state_d = ST_HALT;
                        pc_d    = pc_q;
                    end
                    OP_STO:  wr_c = 1'b1;
                    OP_LD: begin
                        rd_c  = 1'b1;
                        acc_d = i_data_dm;
                    end
                    OP_LDI:  acc_d = imm;
                    OP_ADD: begin
                        rd_c  = 1'b1;
                        acc_d = acc_q + i_data_dm;
                    end
                    OP_ADDI: acc_d = acc_q + imm;
                    OP_SUB: begin
                        rd_c  = 1'b1;
                        acc_d = acc_q - i_data_dm;
                    end
                    OP_SUBI: acc_d = acc_q - imm;
                    default: ;
                endcase
            end
            ST_HALT: ;
            default: state_d = ST_IDLE;
        endcase
    end

    assign o_addr_pm = pc_q;
    assign o_addr_dm = addr_dm_c;
    assign o_Rd      = rd_c;
    assign o_Wr      = wr_c;
    assign o_data_dm = acc_q;
    assign o_acc     = acc_q;
    assign o_done    = (state_q == ST_HALT);
    assign o_cycles  = cyc_q;

endmodule

// File: tb/tb_bip_core.sv
// Bench for bip_core: program/data memories around the core and an
// instruction-level reference model of the ISA.
module tb_bip_core;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] instdata;
    logic [15:0] data_dm;
    logic [10:0] addr_pm;
    logic [10:0] addr_dm;
    logic        rd;
    logic        wr;
    logic [15:0] data_o;
    logic [15:0] acc;
    logic        done;
    logic [31:0] cycles;

    logic [15:0] pm  [2048];
    logic [15:0] dm  [2048];
    logic [15:0] mdm [2048];

    int checks = 0;
    int errors = 0;

    bip_core #(
        .DBITS(16),
        .IBITS(16),
        .ADDR (11),
        .CBITS(32)
    ) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_start   (start),
        .i_instdata(instdata),
        .i_data_dm (data_dm),
        .o_addr_pm (addr_pm),
        .o_addr_dm (addr_dm),
        .o_Rd      (rd),
        .o_Wr      (wr),
        .o_data_dm (data_o),
        .o_acc     (acc),
        .o_done    (done),
        .o_cycles  (cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read program memory, sync-write / comb-read data memory.
    always @(posedge clk) begin
        instdata <= pm[addr_pm];
        if (wr) dm[addr_dm] <= data_o;
    end
    assign data_dm = dm[addr_dm];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] enc(input logic [4:0] op, input logic [10:0] opnd);
        return {op, opnd};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic fill_pm(input logic [15:0] v);
        for (int i = 0; i < 2048; i++) pm[i] = v;
    endtask

    task automatic check_idle_zero(input string tag);
        check_eq({tag, "_pc"},    32'(addr_pm), 32'd0);
        check_eq({tag, "_adm"},   32'(addr_dm), 32'd0);
        check_eq({tag, "_rd"},    32'(rd),      32'd0);
        check_eq({tag, "_wr"},    32'(wr),      32'd0);
        check_eq({tag, "_wdata"}, 32'(data_o),  32'd0);
        check_eq({tag, "_acc"},   32'(acc),     32'd0);
        check_eq({tag, "_done"},  32'(done),    32'd0);
        check_eq({tag, "_cyc"},   cycles,       32'd0);
    endtask

    // Starts the core from IDLE and follows it instruction by instruction.
    // rst_instr >= 0 asserts reset during the EXEC of that instruction index.
    // patch0 replaces address 0 with HLT once the first instruction has run.
    task automatic run_prog(input int rst_instr, input bit patch0);
        logic [15:0] macc, ins, imm, mem;
        logic [10:0] mpc, opnd;
        logic [4:0]  op;
        logic [31:0] mcyc;
        bit          halted;
        int          k;
        macc = 16'd0; mpc = 11'd0; mcyc = 32'd0; halted = 1'b0; k = 0;
        for (int i = 0; i < 2048; i++) mdm[i] = dm[i];
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (!halted) begin
            check_eq("f_pc",   32'(addr_pm), 32'(mpc));
            check_eq("f_rd",   32'(rd),      32'd0);
            check_eq("f_wr",   32'(wr),      32'd0);
            check_eq("f_done", 32'(done),    32'd0);
            check_eq("f_cyc",  cycles,       mcyc);
            @(negedge clk);
            ins  = pm[mpc];
            op   = ins[15:11];
            opnd = ins[10:0];
            imm  = {{5{opnd[10]}}, opnd};
            mem  = mdm[opnd];
            check_eq("e_rd",    32'(rd), 32'(op == 5'd2 || op == 5'd4 || op == 5'd6));
            check_eq("e_wr",    32'(wr), 32'(op == 5'd1));
            check_eq("e_adm",   32'(addr_dm), 32'(opnd));
            check_eq("e_wdata", 32'(data_o),  32'(macc));
            check_eq("e_acc",   32'(acc),     32'(macc));
            check_eq("e_pc",    32'(addr_pm), 32'(mpc));
            check_eq("e_cyc",   cycles,       mcyc + 32'd1);
            if (k == rst_instr) begin
                rst = 1'b0;
                @(negedge clk);
                check_idle_zero("rst_mid");
                rst = 1'b1;
                return;
            end
            case (op)
                5'd0: halted = 1'b1;
                5'd1: mdm[opnd] = macc;
                5'd2: macc = mem;
                5'd3: macc = imm;
                5'd4: macc = macc + mem;
                5'd5: macc = macc + imm;
                5'd6: macc = macc - mem;
                5'd7: macc = macc - imm;
                default: ;
            endcase
            if (!halted) mpc = mpc + 11'd1;
            mcyc = mcyc + 32'd2;
            if (patch0 && k == 0) pm[0] = 16'h0000;
            k++;
            @(negedge clk);
        end
        check_eq("h_done", 32'(done),    32'd1);
        check_eq("h_pc",   32'(addr_pm), 32'(mpc));
        check_eq("h_acc",  32'(acc),     32'(macc));
        check_eq("h_cyc",  cycles,       mcyc);
        check_eq("h_rd",   32'(rd),      32'd0);
        check_eq("h_wr",   32'(wr),      32'd0);
        start = 1'b1;
        repeat (3) @(negedge clk);
        start = 1'b0;
        check_eq("hs_done", 32'(done),    32'd1);
        check_eq("hs_pc",   32'(addr_pm), 32'(mpc));
        check_eq("hs_cyc",  cycles,       mcyc);
    endtask

    initial begin
        rst   = 1'b0;
        start = 1'b0;
        for (int i = 0; i < 2048; i++) dm[i] = 16'd0;
        fill_pm(16'h0000);

        // Reset then idle with start low.
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (10) @(negedge clk);
        check_idle_zero("idle");

        // LDI 5; ADDI 3; STO 7; HLT
        pm[0] = enc(5'd3, 11'd5);
        pm[1] = enc(5'd5, 11'd3);
        pm[2] = enc(5'd1, 11'd7);
        pm[3] = enc(5'd0, 11'd0);
        run_prog(-1, 1'b0);
        check_eq("a_acc",  32'(acc),     32'd8);
        check_eq("a_cyc",  cycles,       32'd8);
        check_eq("a_pc",   32'(addr_pm), 32'd3);
        check_eq("a_mem7", 32'(dm[7]),   32'd8);

        // Reset during EXEC of the STO, then rerun from address 0.
        do_reset();
        dm[7] = 16'd0;
        run_prog(2, 1'b0);
        run_prog(-1, 1'b0);
        check_eq("r_acc", 32'(acc),   32'd8);
        check_eq("r_cyc", cycles,     32'd8);
        check_eq("r_mem", 32'(dm[7]), 32'd8);

        // Modulo wrap and sign-extended immediates.
        do_reset();
        fill_pm(16'h0000);
        dm[2] = 16'h7FFF;
        pm[0] = enc(5'd2, 11'd2);
        pm[1] = enc(5'd5, 11'd1);
        pm[2] = enc(5'd7, 11'h7FF);
        pm[3] = enc(5'd3, 11'd0);
        pm[4] = enc(5'd6, 11'd2);
        run_prog(-1, 1'b0);
        check_eq("b_acc", 32'(acc), 32'h8001);

        // Unused opcodes behave as NOP.
        do_reset();
        fill_pm(16'h0000);
        pm[0] = enc(5'd3, 11'd9);
        pm[1] = enc(5'b11111, 11'd5);
        pm[2] = enc(5'b01000, 11'd6);
        run_prog(-1, 1'b0);
        check_eq("n_acc", 32'(acc),     32'd9);
        check_eq("n_pc",  32'(addr_pm), 32'd3);

        // PC wraps from the top address back to 0 and halts there.
        do_reset();
        fill_pm(enc(5'b01000, 11'd0));
        pm[0]    = enc(5'd3, 11'd5);
        pm[2047] = enc(5'd5, 11'd1);
        run_prog(-1, 1'b1);
        check_eq("w_pc",  32'(addr_pm), 32'd0);
        check_eq("w_acc", 32'(acc),     32'd6);
        check_eq("w_cyc", cycles,       32'd4098);

        // Random programs against the reference model.
        for (int t = 0; t < 20; t++) begin
            int n;
            logic [4:0] op;
            do_reset();
            fill_pm(16'h0000);
            for (int i = 0; i < 32; i++) dm[i] = 16'($urandom);
            n = int'($urandom_range(4, 24));
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 3) == 0) op = 5'($urandom_range(8, 31));
                else                           op = 5'($urandom_range(1, 7));
                if ($urandom_range(0, 1) == 0) pm[i] = enc(op, 11'($urandom_range(0, 31)));
                else                           pm[i] = enc(op, 11'($urandom));
            end
            run_prog(-1, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
